// File: rtl/led_display_pkg.sv
// Shared mode encodings and helpers for the LED display driver family.
package led_display_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_LATCH = 2'b00;
    localparam mode_t MODE_PULSE = 2'b01;
    localparam mode_t MODE_BLINK = 2'b10;

    // Encoding 2'b11 has no mode of its own and behaves as LATCH.
    function automatic mode_t effective_mode(input mode_t m);
        return (m == MODE_PULSE || m == MODE_BLINK) ? m : MODE_LATCH;
    endfunction

    function automatic logic is_timed(input mode_t m);
        return (m == MODE_PULSE) || (m == MODE_BLINK);
    endfunction

endpackage

// File: rtl/led_channel_timer.sv
// One LED channel countdown: load restarts at HOLD_CYCLES, counts to zero and stops.
module led_channel_timer #(
    parameter int HOLD_CYCLES = 8,
    localparam int TW = $clog2(HOLD_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          clr,
    output logic [TW-1:0] count,
    output logic          active
);

    // Load wins over decrement so a re-strobe restarts a full hold period.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= TW'(HOLD_CYCLES);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign active = (count != '0);

endmodule

// File: rtl/led_pulse_display.sv
// Keypad-index to LED-bank driver with LATCH, PULSE and BLINK modes.
// Define LED_HIT_COUNT_EN to build the saturating accepted-strobe counter.
module led_pulse_display
    import led_display_pkg::*;
#(
    parameter int NUM_LEDS    = 10,
    parameter int IDX_W       = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int BLINK_HALF  = 4,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    num,
    input  logic                num_valid,
    input  logic [1:0]          mode,
    input  logic                clear,
    output logic [NUM_LEDS-1:0] led,
    output logic                busy,
    output logic [CNT_W-1:0]    hit_count
);

    localparam int TW = $clog2(HOLD_CYCLES + 1);
    localparam int PW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    mode_t               mode_q;
    mode_t               cur_mode;
    logic                mode_chg;
    logic                flush;
    logic                accept;
    logic                in_range;
    logic [NUM_LEDS-1:0] onehot;
    logic [NUM_LEDS-1:0] load_vec;
    logic [NUM_LEDS-1:0] act;
    logic [NUM_LEDS-1:0] busy_vec;
    logic [NUM_LEDS-1:0] latch_q;
    logic [PW-1:0]       presc_q;
    logic                phase_q;
    logic [TW-1:0]       cnt [NUM_LEDS];

    // A mode change acts as a clear, and either one swallows a same-cycle strobe.
    assign mode_chg = (mode != mode_q);
    assign flush    = clear || mode_chg;
    assign accept   = num_valid && !flush;
    assign in_range = ({1'b0, num} < (IDX_W + 1)'(NUM_LEDS));
    assign cur_mode = effective_mode(mode_q);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (num == IDX_W'(i)) onehot[i] = 1'b1;
        end
    end

    assign load_vec = (accept && in_range && is_timed(mode_q)) ? onehot : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_LATCH;
        end else begin
            mode_q <= mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            presc_q <= '0;
            phase_q <= 1'b0;
        end else if (presc_q == PW'(BLINK_HALF - 1)) begin
            presc_q <= '0;
            phase_q <= ~phase_q;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Out-of-range strobes in LATCH blank the bank rather than being ignored.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            latch_q <= '0;
        end else if (accept && cur_mode == MODE_LATCH) begin
            latch_q <= in_range ? onehot : '0;
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
        led_channel_timer #(
            .HOLD_CYCLES(HOLD_CYCLES)
        ) u_timer (
            .clk    (clk),
            .rst    (rst),
            .load   (load_vec[g]),
            .clr    (flush),
            .count  (cnt[g]),
            .active (act[g])
        );
        assign busy_vec[g] = (cnt[g] != '0);
    end

    always_comb begin
        case (cur_mode)
            MODE_PULSE: led = act;
            MODE_BLINK: led = act & {NUM_LEDS{phase_q}};
            default:    led = latch_q;
        endcase
    end

    assign busy = |busy_vec;

`ifdef LED_HIT_COUNT_EN
    logic [CNT_W-1:0] hit_q;

    // Cleared by clear but deliberately kept across mode changes.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hit_q <= '0;
        end else if (accept && in_range && hit_q != {CNT_W{1'b1}}) begin
            hit_q <= hit_q + 1'b1;
        end
    end

    assign hit_count = hit_q;
`else
    assign hit_count = '0;
`endif

endmodule

// File: tb/tb_led_pulse_display.sv
// Directed self-checking bench for led_pulse_display (default geometry, CNT_W=2).
module tb_led_pulse_display;

    logic       clk;
    logic       rst;
    logic [3:0] num;
    logic       num_valid;
    logic [1:0] mode;
    logic       clear;
    logic [9:0] led;
    logic       busy;
    logic [1:0] hit_count;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef LED_HIT_COUNT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    led_pulse_display #(
        .NUM_LEDS(10), .IDX_W(4), .HOLD_CYCLES(8), .BLINK_HALF(4), .CNT_W(2)
    ) dut (
        .clk(clk), .rst(rst), .num(num), .num_valid(num_valid), .mode(mode),
        .clear(clear), .led(led), .busy(busy), .hit_count(hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int n);
        num       = 4'(n);
        num_valid = 1'b1;
        tick();
        num_valid = 1'b0;
    endtask

    int hit_idx [6] = '{1, 12, 2, 3, 4, 5};
    int hit_exp [6] = '{1, 1, 2, 3, 3, 3};

    initial begin
        rst = 1'b1; num = '0; num_valid = 1'b0; mode = 2'b00; clear = 1'b0;
        tick();
        tick();
        check_eq("rst_led", led, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_hit", hit_count, 0);
        rst = 1'b0;
        tick();

        // LATCH: one-hot hold, then out-of-range blanks
        strobe(3);
        for (int c = 0; c < 20; c++) begin
            check_eq("latch_hold", led, 10'h008);
            check_eq("latch_busy", busy, 0);
            tick();
        end
        strobe(12);
        check_eq("latch_oor", led, 0);

        // PULSE: single channel, exactly 8 cycles
        mode = 2'b01;
        tick();
        check_eq("pulse_enter", led, 0);
        strobe(2);
        for (int c = 1; c <= 10; c++) begin
            check_eq("pulse_led2", led[2], (c <= 8));
            check_eq("pulse_busy", busy, (c <= 8));
            tick();
        end

        // PULSE: re-strobe at t0+5 extends through t0+13
        strobe(2);
        for (int c = 1; c <= 15; c++) begin
            check_eq("restrobe_led2", led[2], (c <= 13));
            if (c == 5) begin
                num = 4'd2; num_valid = 1'b1;
            end else begin
                num_valid = 1'b0;
            end
            tick();
        end
        num_valid = 1'b0;

        // PULSE: two overlapping channels
        strobe(1);
        for (int c = 1; c <= 12; c++) begin
            check_eq("overlap_led1", led[1], (c <= 8));
            check_eq("overlap_led7", led[7], (c >= 3 && c <= 10));
            check_eq("overlap_busy", busy, (c <= 10));
            if (c == 2) begin
                num = 4'd7; num_valid = 1'b1;
            end else begin
                num_valid = 1'b0;
            end
            tick();
        end
        num_valid = 1'b0;

        // BLINK: strobe on the cycle after entering
        mode = 2'b10;
        tick();
        strobe(0);
        for (int c = 1; c <= 12; c++) begin
            check_eq("blink_led0", led[0], (c >= 4 && c <= 7));
            check_eq("blink_busy", busy, (c <= 8));
            tick();
        end

        // clear with simultaneous strobe while channels are active
        mode = 2'b01;
        tick();
        strobe(1);
        strobe(3);
        tick();
        check_eq("pre_clear_led", led, 10'h00A);
        clear = 1'b1; num = 4'd5; num_valid = 1'b1;
        tick();
        clear = 1'b0; num_valid = 1'b0;
        check_eq("clear_led", led, 0);
        check_eq("clear_busy", busy, 0);
        tick();
        check_eq("clear_no_ch5", led, 0);

        // mode change mid-pulse with simultaneous strobe
        strobe(4);
        tick();
        check_eq("pre_mchg_led", led, 10'h010);
        mode = 2'b00; num = 4'd5; num_valid = 1'b1;
        tick();
        num_valid = 1'b0;
        check_eq("mchg_led", led, 0);
        check_eq("mchg_busy", busy, 0);
        tick();
        check_eq("mchg_no_latch", led, 0);

        // mode 11 behaves as LATCH
        mode = 2'b11;
        tick();
        strobe(6);
        check_eq("mode3_latch", led, 10'h040);
        check_eq("mode3_busy", busy, 0);

        // hit counter saturation at CNT_W=2
        mode = 2'b00; rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("hit_rst0", hit_count, 0);
        for (int k = 0; k < 6; k++) begin
            strobe(hit_idx[k]);
            check_eq("hit_count", hit_count, HIT_EN ? hit_exp[k] : 0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("hit_rst1", hit_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
